// File: rtl/hotspot_ctrl.sv
// Hotspot overlay controller: accepts beamformer locations, commits them on frame start, drops the overlay after a run of empty frames.
// Optional HOTSPOT_SMOOTH_EN: quarter-step smoothing of commits made while already tracking.
module hotspot_ctrl #(
  parameter int H_ACT       = 480,
  parameter int V_ACT       = 272,
  parameter int HOLD_FRAMES = 30
) (
  input  logic               clk_pix,
  input  logic               rst_n,
  input  logic               vsync,
  input  logic               loc_valid,
  output logic               loc_ready,
  input  logic signed [15:0] loc_x,
  input  logic signed [15:0] loc_y,
  output logic [15:0]        spot_x,
  output logic [15:0]        spot_y,
  output logic               spot_en,
  output logic               spot_upd
);

  // state  | meaning
  // IDLE   | overlay off, waiting for a frame start with a pending sample
  // COMMIT | one cycle: load spot from the pending sample
  // TRACK  | overlay on, counting frames without a new sample
  typedef enum logic [1:0] {IDLE, COMMIT, TRACK} state_t;

  localparam logic signed [15:0] X_MAX     = 16'(H_ACT - 1);
  localparam logic signed [15:0] Y_MAX     = 16'(V_ACT - 1);
  localparam logic [7:0]         MISS_LAST = 8'(HOLD_FRAMES - 1);

  state_t             state_q, state_d;
  logic               vsync_q, fs_q, fs_d;
  logic               pend_v_q, pend_v_d;
  logic signed [15:0] pend_x_q, pend_x_d, pend_y_q, pend_y_d;
  logic [7:0]         miss_cnt_q, miss_cnt_d;
  logic [15:0]        spot_x_q, spot_x_d, spot_y_q, spot_y_d;
  logic               spot_en_q, spot_en_d;
  logic               spot_upd_q, spot_upd_d;
  logic [15:0]        clamp_x, clamp_y;
  logic               hs;

  function automatic logic [15:0] clamp(input logic signed [15:0] v,
                                        input logic signed [15:0] lim);
    if (v < 16'sd0)   return 16'd0;
    else if (v > lim) return lim;
    else              return v;
  endfunction

`ifdef HOTSPOT_SMOOTH_EN
  logic               from_track_q, from_track_d;
  logic signed [16:0] dx, dy, sx, sy;
`endif

  assign loc_ready = (state_q != COMMIT);
  assign spot_x    = spot_x_q;
  assign spot_y    = spot_y_q;
  assign spot_en   = spot_en_q;
  assign spot_upd  = spot_upd_q;
  assign clamp_x   = clamp(pend_x_q, X_MAX);
  assign clamp_y   = clamp(pend_y_q, Y_MAX);

  always_comb begin
    state_d    = state_q;
    fs_d       = vsync & ~vsync_q;
    pend_v_d   = pend_v_q;
    pend_x_d   = pend_x_q;
    pend_y_d   = pend_y_q;
    miss_cnt_d = miss_cnt_q;
    spot_x_d   = spot_x_q;
    spot_y_d   = spot_y_q;
    spot_en_d  = spot_en_q;
    spot_upd_d = 1'b0;
    hs         = loc_valid & loc_ready;
`ifdef HOTSPOT_SMOOTH_EN
    from_track_d = from_track_q;
    dx = $signed({1'b0, clamp_x}) - $signed({1'b0, spot_x_q});
    dy = $signed({1'b0, clamp_y}) - $signed({1'b0, spot_y_q});
    sx = $signed({1'b0, spot_x_q}) + (dx >>> 2);
    sy = $signed({1'b0, spot_y_q}) + (dy >>> 2);
`endif
    if (hs) begin
      pend_v_d = 1'b1;
      pend_x_d = loc_x;
      pend_y_d = loc_y;
    end
    // Frame decisions use the registered pend_v, so a same-cycle sample waits for the next frame.
    case (state_q)
      IDLE: begin
        if (fs_q && pend_v_q) begin
          state_d = COMMIT;
`ifdef HOTSPOT_SMOOTH_EN
          from_track_d = 1'b0;
`endif
        end
      end
      COMMIT: begin
`ifdef HOTSPOT_SMOOTH_EN
        spot_x_d = from_track_q ? sx[15:0] : clamp_x;
        spot_y_d = from_track_q ? sy[15:0] : clamp_y;
`else
        spot_x_d = clamp_x;
        spot_y_d = clamp_y;
`endif
        pend_v_d   = 1'b0;
        miss_cnt_d = 8'd0;
        spot_upd_d = 1'b1;
        spot_en_d  = 1'b1;
        state_d    = TRACK;
      end
      TRACK: begin
        if (fs_q) begin
          if (pend_v_q) begin
            state_d = COMMIT;
`ifdef HOTSPOT_SMOOTH_EN
            from_track_d = 1'b1;
`endif
          end else if (miss_cnt_q == MISS_LAST) begin
            state_d    = IDLE;
            miss_cnt_d = 8'd0;
            spot_en_d  = 1'b0;
          end else begin
            miss_cnt_d = miss_cnt_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      vsync_q    <= 1'b0;
      fs_q       <= 1'b0;
      pend_v_q   <= 1'b0;
      pend_x_q   <= '0;
      pend_y_q   <= '0;
      miss_cnt_q <= 8'd0;
      spot_x_q   <= 16'd0;
      spot_y_q   <= 16'd0;
      spot_en_q  <= 1'b0;
      spot_upd_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      vsync_q    <= vsync;
      fs_q       <= fs_d;
      pend_v_q   <= pend_v_d;
      pend_x_q   <= pend_x_d;
      pend_y_q   <= pend_y_d;
      miss_cnt_q <= miss_cnt_d;
      spot_x_q   <= spot_x_d;
      spot_y_q   <= spot_y_d;
      spot_en_q  <= spot_en_d;
      spot_upd_q <= spot_upd_d;
    end
  end

`ifdef HOTSPOT_SMOOTH_EN
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) from_track_q <= 1'b0;
    else        from_track_q <= from_track_d;
  end
`endif

endmodule

// File: tb/tb_hotspot_ctrl.sv
// Directed bench for hotspot_ctrl: table of clamping vectors plus hand sequences for hold-off, same-cycle handshake and reset in COMMIT.
module tb_hotspot_ctrl;
  logic               clk_pix = 1'b0;
  logic               rst_n   = 1'b0;
  logic               vsync   = 1'b0;
  logic               loc_valid = 1'b0;
  logic               loc_ready;
  logic signed [15:0] loc_x = '0;
  logic signed [15:0] loc_y = '0;
  logic [15:0]        spot_x, spot_y;
  logic               spot_en, spot_upd;

  int n_checks = 0;
  int n_errors = 0;
  int model_x = 0, model_y = 0;
  bit model_trk = 1'b0;

  typedef struct {
    int x;
    int y;
    int ex;
    int ey;
  } vec_t;
  vec_t vecs[7];

  hotspot_ctrl #(.H_ACT(480), .V_ACT(272), .HOLD_FRAMES(3)) dut (
    .clk_pix(clk_pix), .rst_n(rst_n), .vsync(vsync),
    .loc_valid(loc_valid), .loc_ready(loc_ready),
    .loc_x(loc_x), .loc_y(loc_y),
    .spot_x(spot_x), .spot_y(spot_y),
    .spot_en(spot_en), .spot_upd(spot_upd)
  );

  always #5 clk_pix = ~clk_pix;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int smooth(input int prev, input int c, input bit trk);
`ifdef HOTSPOT_SMOOTH_EN
    return trk ? prev + ((c - prev) >>> 2) : c;
`else
    return c;
`endif
  endfunction

  task automatic model_commit(input int cx, input int cy);
    model_x   = smooth(model_x, cx, model_trk);
    model_y   = smooth(model_y, cy, model_trk);
    model_trk = 1'b1;
  endtask

  task automatic offer(input int x, input int y);
    @(negedge clk_pix);
    loc_valid = 1'b1;
    loc_x = 16'(x);
    loc_y = 16'(y);
    chk("offer_ready", int'(loc_ready), 1);
    @(negedge clk_pix);
    loc_valid = 1'b0;
  endtask

  // vsync rises in the current cycle N; spot and spot_upd are visible in cycle N+3.
  task automatic commit_frame(input string name);
    vsync = 1'b1;
    @(posedge clk_pix);
    @(negedge clk_pix);
    chk({name, "_ready_fs"}, int'(loc_ready), 1);
    @(posedge clk_pix);
    @(negedge clk_pix);
    chk({name, "_ready_commit"}, int'(loc_ready), 0);
    chk({name, "_upd_early"}, int'(spot_upd), 0);
    @(negedge clk_pix);
    chk({name, "_upd"}, int'(spot_upd), 1);
    chk({name, "_x"}, int'(spot_x), model_x);
    chk({name, "_y"}, int'(spot_y), model_y);
    chk({name, "_en"}, int'(spot_en), 1);
    chk({name, "_ready_after"}, int'(loc_ready), 1);
    @(negedge clk_pix);
    chk({name, "_upd_clear"}, int'(spot_upd), 0);
    vsync = 1'b0;
    repeat (2) @(negedge clk_pix);
  endtask

  task automatic empty_frame(input string name, input int exp_en);
    vsync = 1'b1;
    @(posedge clk_pix);
    @(posedge clk_pix);
    @(negedge clk_pix);
    chk({name, "_en"}, int'(spot_en), exp_en);
    chk({name, "_upd"}, int'(spot_upd), 0);
    chk({name, "_x"}, int'(spot_x), model_x);
    chk({name, "_y"}, int'(spot_y), model_y);
    @(negedge clk_pix);
    chk({name, "_upd2"}, int'(spot_upd), 0);
    vsync = 1'b0;
    repeat (2) @(negedge clk_pix);
  endtask

  initial begin
    vecs[0] = '{x: 100,    y: 50,    ex: 100, ey: 50};
    vecs[1] = '{x: -20,    y: 300,   ex: 0,   ey: 271};
    vecs[2] = '{x: 600,    y: -1,    ex: 479, ey: 0};
    vecs[3] = '{x: 479,    y: 271,   ex: 479, ey: 271};
    vecs[4] = '{x: 480,    y: 272,   ex: 479, ey: 271};
    vecs[5] = '{x: 0,      y: 0,     ex: 0,   ey: 0};
    vecs[6] = '{x: -32768, y: 32767, ex: 0,   ey: 271};

    repeat (2) @(negedge clk_pix);
    chk("rst_x", int'(spot_x), 0);
    chk("rst_y", int'(spot_y), 0);
    chk("rst_en", int'(spot_en), 0);
    chk("rst_upd", int'(spot_upd), 0);
    chk("rst_ready", int'(loc_ready), 1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_pix);

    for (int i = 0; i < 7; i++) begin
      offer(vecs[i].x, vecs[i].y);
      model_commit(vecs[i].ex, vecs[i].ey);
      commit_frame($sformatf("vec%0d", i));
    end

    // HOLD_FRAMES=3: overlay drops on the third empty frame.
    empty_frame("hold1", 1);
    empty_frame("hold2", 1);
    empty_frame("hold3", 0);
    model_trk = 1'b0;
    empty_frame("idle_empty", 0);

    // Handshake in the fs cycle: no commit this frame.
    @(negedge clk_pix);
    vsync = 1'b1;
    @(negedge clk_pix);
    loc_valid = 1'b1;
    loc_x = 16'sd200;
    loc_y = 16'sd100;
    chk("same_ready", int'(loc_ready), 1);
    @(negedge clk_pix);
    loc_valid = 1'b0;
    chk("same_no_commit", int'(loc_ready), 1);
    @(negedge clk_pix);
    chk("same_en", int'(spot_en), 0);
    chk("same_upd", int'(spot_upd), 0);
    chk("same_x", int'(spot_x), model_x);
    vsync = 1'b0;
    repeat (2) @(negedge clk_pix);
    model_commit(200, 100);
    commit_frame("same_next");

    // Reset while in COMMIT discards the sample.
    offer(50, 60);
    vsync = 1'b1;
    @(posedge clk_pix);
    @(posedge clk_pix);
    @(negedge clk_pix);
    chk("rc_in_commit", int'(loc_ready), 0);
    rst_n = 1'b0;
    #1;
    chk("rc_x", int'(spot_x), 0);
    chk("rc_y", int'(spot_y), 0);
    chk("rc_en", int'(spot_en), 0);
    chk("rc_upd", int'(spot_upd), 0);
    chk("rc_ready", int'(loc_ready), 1);
    @(negedge clk_pix);
    rst_n = 1'b1;
    vsync = 1'b0;
    model_x = 0;
    model_y = 0;
    model_trk = 1'b0;
    repeat (2) @(negedge clk_pix);
    empty_frame("rc_after", 0);

    // Smoothing case: (100,100) tracked, then (140,60).
    offer(100, 100);
    model_commit(100, 100);
    commit_frame("sm_a");
    offer(140, 60);
    model_commit(140, 60);
    commit_frame("sm_b");
`ifdef HOTSPOT_SMOOTH_EN
    chk("sm_x_const", int'(spot_x), 110);
    chk("sm_y_const", int'(spot_y), 90);
`else
    chk("sm_x_const", int'(spot_x), 140);
    chk("sm_y_const", int'(spot_y), 60);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
